trace_capture: RTL and testbench

- Synthesizable event recorder for the riscv core. Captures register-file writes and data-memory reads/writes into a timestamped circular buffer.
- Drains the buffer through a valid/ready stream, replacing simulation-only console monitoring.
- Generalised in data/address width, buffer depth and timestamp width.
- Adds overflow accounting and illegal-access detection.

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_fifo2w.sv | 68 ++++++
 rtl/trace_capture.sv | 124 ++++++++++++
 tb/tb_trace_capture.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared trace definitions: event kinds, fixed constants and the default entry layout.
package trace_pkg;

    typedef enum logic [1:0] {
        TK_NONE   = 2'd0,
        TK_REG_WR = 2'd1,
        TK_MEM_WR = 2'd2,
        TK_MEM_RD = 2'd3
    } trace_kind_e;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DROP_W    = 16;

    // Layout at default widths (AW=9, DW=32, TSW=16) for monitors that share it.
    typedef struct packed {
        trace_kind_e  kind;
        logic [8:0]   idx;
        logic [31:0]  data;
        logic [15:0]  stamp;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo2w.sv
// Circular buffer taking up to two pushes and one pop per cycle; head is a registered copy.
module trace_fifo2w #(
    parameter int unsigned W     = 59,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push0,
    input  logic          push1,
    input  logic [W-1:0]  din0,
    input  logic [W-1:0]  din1,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr1;
    logic [PW-1:0] rd_nxt;
    logic          pop_fire;
    logic [CW-1:0] count_nxt;
    logic [W-1:0]  head_nxt;

    assign pop_fire  = pop && (count != '0);
    assign free      = CW'(DEPTH) - count + CW'(pop_fire);
    assign wr_ptr1   = wr_ptr + 1'b1;
    assign rd_nxt    = rd_ptr + PW'(pop_fire);
    assign count_nxt = count + CW'(push0) + CW'(push1) - CW'(pop_fire);

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]  <= din0;
        if (push1) mem[wr_ptr1] <= din1;
    end

    // An entry written this edge into the slot that becomes head must bypass storage.
    always_comb begin
        head_nxt = '0;
        if (count_nxt != '0) begin
            if (push0 && (rd_nxt == wr_ptr))
                head_nxt = din0;
            else if (push1 && (rd_nxt == wr_ptr1))
                head_nxt = din1;
            else
                head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            head   <= head_nxt;
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Timestamped recorder of register writes and memory accesses, drained by valid/ready.
// Optional address window on memory events: define TRACE_ADDR_FILTER_EN.
module trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 9,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TSW   = 16
`ifdef TRACE_ADDR_FILTER_EN
    ,
    parameter int unsigned FLT_LO = 0,
    parameter int unsigned FLT_HI = (1 << AW) - 1
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     reg_write_sig,
    input  logic [REG_IDX_W-1:0]     reg_num,
    input  logic [DW-1:0]            reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [AW-1:0]            addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [DW-1:0]            rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [AW-1:0]            out_idx,
    output logic [DW-1:0]            out_data,
    output logic [TSW-1:0]           out_stamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     proto_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = 2 + AW + DW + TSW;

    logic [TSW-1:0]  stamp;
    logic            in_range;
    logic            reg_ev;
    logic            mem_ev;
    trace_kind_e     mem_kind;
    logic [EW-1:0]   reg_ent;
    logic [EW-1:0]   mem_ent;
    logic [EW-1:0]   din0;
    logic [EW-1:0]   din1;
    logic            push0;
    logic            push1;
    logic [1:0]      n_drop;
    logic [CW-1:0]   free;
    logic [EW-1:0]   head;
    logic [DROP_W:0] drop_sum;

`ifdef TRACE_ADDR_FILTER_EN
    assign in_range = (32'(addr) >= FLT_LO) && (32'(addr) <= FLT_HI);
`else
    assign in_range = 1'b1;
`endif

    assign reg_ev   = en && reg_write_sig;
    assign mem_ev   = en && (wr ^ rd) && in_range;
    assign mem_kind = wr ? TK_MEM_WR : TK_MEM_RD;
    assign reg_ent  = {TK_REG_WR, AW'(reg_num), reg_data, stamp};
    assign mem_ent  = {mem_kind, addr, (wr ? wr_data : rd_data), stamp};

    // Register event always takes the first free slot; memory event the next.
    always_comb begin
        push0  = 1'b0;
        push1  = 1'b0;
        din0   = reg_ent;
        din1   = mem_ent;
        n_drop = 2'd0;
        if (reg_ev && mem_ev) begin
            push0  = (free != '0);
            push1  = (free > CW'(1));
            n_drop = 2'd2 - {1'b0, push0} - {1'b0, push1};
        end else if (reg_ev || mem_ev) begin
            if (mem_ev) din0 = mem_ent;
            push0  = (free != '0);
            n_drop = {1'b0, ~push0};
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(n_drop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stamp     <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            stamp    <= stamp + 1'b1;
            drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            if (en && wr && rd) proto_err <= 1'b1;
        end
    end

    trace_fifo2w #(
        .W     (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (push0),
        .push1 (push1),
        .din0  (din0),
        .din1  (din1),
        .pop   (out_ready),
        .head  (head),
        .count (count),
        .free  (free)
    );

    assign out_valid = (count != '0);
    assign out_kind  = head[EW-1 -: 2];
    assign out_idx   = head[DW+TSW +: AW];
    assign out_data  = head[TSW +: DW];
    assign out_stamp = head[TSW-1:0];

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with a queue scoreboard drained by a handshake monitor.
module tb_trace_capture;

    logic        clk;
    logic        reset;
    logic        en;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [8:0]  out_idx;
    logic [31:0] out_data;
    logic [15:0] out_stamp;
    logic [4:0]  count;
    logic [15:0] drop_cnt;
    logic        proto_err;

    typedef struct {
        logic [1:0]  kind;
        logic [8:0]  idx;
        logic [31:0] data;
        logic [15:0] stamp;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] tb_cyc;
    logic [15:0] s;

    trace_capture #(
        .DW(32), .AW(9), .DEPTH(16), .TSW(16)
`ifdef TRACE_ADDR_FILTER_EN
        , .FLT_HI(255)
`endif
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_idx(out_idx), .out_data(out_data), .out_stamp(out_stamp),
        .count(count), .drop_cnt(drop_cnt), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release; equals the stamp of an event driven now.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 16'd1;
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got kind=%0d idx=%0d data=%h stamp=%0d, expected no entry",
                         out_kind, out_idx, out_data, out_stamp);
            end else begin
                mon_e = q.pop_front();
                if (out_kind !== mon_e.kind || out_idx !== mon_e.idx ||
                    out_data !== mon_e.data || out_stamp !== mon_e.stamp) begin
                    errors++;
                    $display("FAIL sb_entry: got kind=%0d idx=%0d data=%h stamp=%0d, expected kind=%0d idx=%0d data=%h stamp=%0d",
                             out_kind, out_idx, out_data, out_stamp,
                             mon_e.kind, mon_e.idx, mon_e.data, mon_e.stamp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ent(input logic [1:0] k, input logic [8:0] i,
                              input logic [31:0] d, input logic [15:0] st);
        exp_t e;
        e.kind = k; e.idx = i; e.data = d; e.stamp = st;
        q.push_back(e);
    endtask

    // Called at #1 after a posedge; holds the inputs for one capture edge.
    task automatic cyc_drive(input logic rw, input logic [4:0] rn, input logic [31:0] rdat,
                             input logic w, input logic r, input logic [8:0] a,
                             input logic [31:0] d);
        reg_write_sig = rw; reg_num = rn; reg_data = rdat;
        wr = w; rd = r; addr = a; wr_data = d; rd_data = d;
        @(posedge clk); #1;
        reg_write_sig = 0; reg_num = '0; reg_data = '0;
        wr = 0; rd = 0; addr = '0; wr_data = '0; rd_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1; en = 0; out_ready = 1;
        reg_write_sig = 0; reg_num = '0; reg_data = '0;
        wr = 0; rd = 0; addr = '0; wr_data = '0; rd_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_proto", 32'(proto_err), 0);
        chk("rst_kind", 32'(out_kind), 0);
        reset = 0;
        en = 1;

        // First event three cycles after release carries stamp 3.
        idle(3);
        expect_ent(2'd1, 9'd5, 32'h0000_00AA, 16'd3);
        cyc_drive(1, 5'd5, 32'h0000_00AA, 0, 0, 9'd0, 32'h0);
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_stamp", 32'(out_stamp), 3);
        idle(3);

        // Dual push in one cycle: register entry ahead of memory entry, same stamp.
        out_ready = 0;
        s = tb_cyc;
        expect_ent(2'd1, 9'd7, 32'h11, s);
        expect_ent(2'd2, 9'd20, 32'h22, s);
        cyc_drive(1, 5'd7, 32'h11, 1, 0, 9'd20, 32'h22);
        @(negedge clk);
        chk("t2_count", 32'(count), 2);
        @(posedge clk); #1;
        out_ready = 1;
        idle(3);
        chk("t2_drained", 32'(count), 0);

        s = tb_cyc;
`ifndef TRACE_ADDR_FILTER_EN
        expect_ent(2'd3, 9'd300, 32'hDEAD_BEEF, s);
`endif
        cyc_drive(0, 5'd0, 32'h0, 0, 1, 9'd300, 32'hDEAD_BEEF);
        idle(2);
        chk("flt_drop", 32'(drop_cnt), 0);

        // Disabled capture: nothing recorded, nothing counted as dropped.
        en = 0;
        cyc_drive(1, 5'd9, 32'h99, 1, 0, 9'd4, 32'h44);
        en = 1;
        @(negedge clk);
        chk("en0_count", 32'(count), 0);
        chk("en0_drop", 32'(drop_cnt), 0);
        idle(1);

        s = tb_cyc;
        expect_ent(2'd1, 9'd3, 32'h33, s);
        cyc_drive(1, 5'd3, 32'h33, 1, 1, 9'd8, 32'h88);
        @(negedge clk);
        chk("proto_set", 32'(proto_err), 1);
        chk("proto_count", 32'(count), 1);
        idle(4);
        chk("proto_sticky", 32'(proto_err), 1);

        // Overflow: 20 events into 16 slots, then pop plus event while full.
        out_ready = 0;
        for (int i = 0; i < 20; i++) begin
            s = tb_cyc;
            if (i < 16) expect_ent(2'd1, 9'(i + 1), 32'(100 + i), s);
            cyc_drive(1, 5'(i + 1), 32'(100 + i), 0, 0, 9'd0, 32'h0);
        end
        @(negedge clk);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_drop", 32'(drop_cnt), 4);
        chk("ovf_head_data", out_data, 100);
        chk("ovf_head_idx", 32'(out_idx), 1);
        @(posedge clk); #1;
        out_ready = 1;
        s = tb_cyc;
        expect_ent(2'd1, 9'd30, 32'h3030, s);
        cyc_drive(1, 5'd30, 32'h3030, 0, 0, 9'd0, 32'h0);
        out_ready = 0;
        @(negedge clk);
        chk("full_pop_count", 32'(count), 16);
        chk("full_pop_drop", 32'(drop_cnt), 4);
        chk("full_pop_head", 32'(out_idx), 2);
        @(posedge clk); #1;
        out_ready = 1;
        idle(20);
        chk("ovf_drained", 32'(count), 0);

        // Reset with six entries buffered.
        out_ready = 0;
        for (int i = 0; i < 6; i++)
            cyc_drive(1, 5'(i), 32'(i), 0, 0, 9'd0, 32'h0);
        @(negedge clk);
        chk("mid_count", 32'(count), 6);
        chk("mid_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        reset = 1;
        #1;
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_count", 32'(count), 0);
        chk("mrst_drop", 32'(drop_cnt), 0);
        chk("mrst_proto", 32'(proto_err), 0);
        @(negedge clk);
        reset = 0;
        out_ready = 1;
        idle(2);
        expect_ent(2'd1, 9'd4, 32'h44, 16'd2);
        cyc_drive(1, 5'd4, 32'h44, 0, 0, 9'd0, 32'h0);
        @(negedge clk);
        chk("restart_stamp", 32'(out_stamp), 2);
        idle(3);
        chk("sb_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
